// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32 control slice.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Holds opcode/funct encodings for the supported subset, the ImmSel and
// ALUSel codes driven to the datapath, and the controller state encoding.
package riscv_pkg;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  // funct3 (inst[14:12]) and funct7 (inst[31:25])
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [6:0] F7_ADD  = 7'b0000000;

  // Immediate format select
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_U = 2'b10;

  // ALU operation select
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_PASSB = 4'b0011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

endpackage

// File: rtl/inst_decode.sv
// Combinational decode of the supported RV32 subset into datapath controls.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the sequencer decides when the controls are used.
//
// Ports:
//   inst   in  32  instruction register contents
//   legal  out 1   instruction is one of add/lw/sw/addi/lui
//   is_lw  out 1   load word
//   is_sw  out 1   store word
//   immsel out 2   immediate format
//   bsel   out 1   ALU operand B: 0 = rs2, 1 = immediate
//   alusel out 4   ALU operation
//   wbsel  out 1   write-back source: 0 = memory, 1 = ALU
module inst_decode
  import riscv_pkg::*;
(
  input  logic [31:0] inst,
  output logic        legal,
  output logic        is_lw,
  output logic        is_sw,
  output logic [1:0]  immsel,
  output logic        bsel,
  output logic [3:0]  alusel,
  output logic        wbsel
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  // Register and immediate fields matter to the datapath, not to control.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst[24:15], inst[11:7]};

  always_comb begin
    legal  = 1'b0;
    is_lw  = 1'b0;
    is_sw  = 1'b0;
    immsel = IMM_I;
    bsel   = 1'b0;
    alusel = 4'b0000;
    wbsel  = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        if (funct3 == F3_ADD && funct7 == F7_ADD) begin
          legal  = 1'b1;
          alusel = ALU_ADD;
          wbsel  = 1'b1;
        end
      end
      OPC_LOAD: begin
        if (funct3 == F3_LW) begin
          legal  = 1'b1;
          is_lw  = 1'b1;
          immsel = IMM_I;
          bsel   = 1'b1;
          alusel = ALU_ADD;
        end
      end
      OPC_STORE: begin
        if (funct3 == F3_SW) begin
          legal  = 1'b1;
          is_sw  = 1'b1;
          immsel = IMM_S;
          bsel   = 1'b1;
          alusel = ALU_ADD;
          wbsel  = 1'b1;
        end
      end
      OPC_OPIMM: begin
        if (funct3 == F3_ADDI) begin
          legal  = 1'b1;
          immsel = IMM_I;
          bsel   = 1'b1;
          alusel = ALU_ADD;
          wbsel  = 1'b1;
        end
      end
      OPC_LUI: begin
        legal  = 1'b1;
        immsel = IMM_U;
        bsel   = 1'b1;
        alusel = ALU_PASSB;
        wbsel  = 1'b1;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset controller: FETCH/DECODE/EXEC/MEM/WB sequencing.
// Latency: add/addi/lui 4 cycles, lw 5, sw 4 with mem_ready held high.
// Backpressure: FETCH and MEM hold while mem_ready is low; TRAP holds until reset.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   inst      in  32  instruction register (valid from DECODE)
//   mem_ready in  1   memory completes the current access this cycle
//   PCWEn, IRWEn      PC update / IR load enables (FETCH completion)
//   MemReq, MemRW     memory request, 1 = read / 0 = write
//   ImmSel, RegWEn, Bsel, ALUSel, WBSel   datapath controls
//   illegal   out 1   sticky unsupported-instruction flag
//   retired   out 16  completed-instruction count (wraps)
module multicycle_ctrl
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        mem_ready,
  output logic        PCWEn,
  output logic        IRWEn,
  output logic        MemReq,
  output logic        MemRW,
  output logic [1:0]  ImmSel,
  output logic        RegWEn,
  output logic        Bsel,
  output logic [3:0]  ALUSel,
  output logic        WBSel,
  output logic        illegal,
  output logic [15:0] retired
);

  state_t      state_q, state_d;
  logic        illegal_q;
  logic [15:0] retired_q;
  logic        retire;

  logic       dec_legal;
  logic       dec_is_lw;
  logic       dec_is_sw;
  logic [1:0] dec_immsel;
  logic       dec_bsel;
  logic [3:0] dec_alusel;
  logic       dec_wbsel;

  inst_decode u_decode (
    .inst   (inst),
    .legal  (dec_legal),
    .is_lw  (dec_is_lw),
    .is_sw  (dec_is_sw),
    .immsel (dec_immsel),
    .bsel   (dec_bsel),
    .alusel (dec_alusel),
    .wbsel  (dec_wbsel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
      retired_q <= 16'd0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE && !dec_legal) begin
        illegal_q <= 1'b1;
      end
      if (retire) begin
        retired_q <= retired_q + 16'd1;  // natural wrap 0xFFFF -> 0x0000
      end
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    PCWEn   = 1'b0;
    IRWEn   = 1'b0;
    MemReq  = 1'b0;
    // MemRW idles at read so a write is only ever signalled during a sw access.
    MemRW   = 1'b1;
    ImmSel  = 2'b00;
    RegWEn  = 1'b0;
    Bsel    = 1'b0;
    ALUSel  = 4'b0000;
    WBSel   = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        MemReq = 1'b1;
        if (mem_ready) begin
          IRWEn   = 1'b1;
          PCWEn   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = dec_legal ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        ImmSel  = dec_immsel;
        Bsel    = dec_bsel;
        ALUSel  = dec_alusel;
        state_d = (dec_is_lw || dec_is_sw) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        ImmSel = dec_immsel;
        Bsel   = dec_bsel;
        ALUSel = dec_alusel;
        MemReq = 1'b1;
        // Only lw/sw reach MEM, so anything other than sw is a read.
        MemRW  = !dec_is_sw;
        if (mem_ready) begin
          if (dec_is_lw) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
        end
      end
      ST_WB: begin
        ImmSel  = dec_immsel;
        Bsel    = dec_bsel;
        ALUSel  = dec_alusel;
        RegWEn  = 1'b1;
        WBSel   = dec_wbsel;
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: table of per-cycle vectors plus
// hand-written sequences for counter wrap, reset mid-fetch and trap.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst;
  logic        mem_ready;
  logic        PCWEn, IRWEn, MemReq, MemRW, RegWEn, Bsel, WBSel, illegal;
  logic [1:0]  ImmSel;
  logic [3:0]  ALUSel;
  logic [15:0] retired;

  multicycle_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inst      (inst),
    .mem_ready (mem_ready),
    .PCWEn     (PCWEn),
    .IRWEn     (IRWEn),
    .MemReq    (MemReq),
    .MemRW     (MemRW),
    .ImmSel    (ImmSel),
    .RegWEn    (RegWEn),
    .Bsel      (Bsel),
    .ALUSel    (ALUSel),
    .WBSel     (WBSel),
    .illegal   (illegal),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        pcwen;
    logic        irwen;
    logic        memreq;
    logic        memrw;
    logic [1:0]  immsel;
    logic        regwen;
    logic        bsel;
    logic [3:0]  alusel;
    logic        wbsel;
    logic        illegal;
    logic [15:0] retired;
  } out_t;

  typedef struct packed {
    logic        mr;
    logic [31:0] inst;
    out_t        exp;
  } vec_t;

  localparam logic [31:0] I_ADDI = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] I_ADD  = 32'h002081B3;  // add  x3,x1,x2
  localparam logic [31:0] I_LUI  = 32'h123452B7;  // lui  x5,0x12345
  localparam logic [31:0] I_LW   = 32'h0080A203;  // lw   x4,8(x1)
  localparam logic [31:0] I_SW   = 32'h0020A623;  // sw   x2,12(x1)
  localparam logic [31:0] I_BEQ  = 32'h00000063;  // beq  x0,x0,0
  localparam logic [31:0] I_SUB  = 32'h40000033;  // sub  x0,x0,x0

  int checks   = 0;
  int failures = 0;
  vec_t vq[$];

  function automatic out_t o(logic pc, logic ir, logic mq, logic rw, logic [1:0] imm,
                             logic rg, logic bs, logic [3:0] alu, logic wb,
                             logic ill, logic [15:0] r);
    out_t x;
    x = {pc, ir, mq, rw, imm, rg, bs, alu, wb, ill, r};
    return x;
  endfunction

  function automatic out_t e_fetch(logic mr, logic [15:0] r);
    return o(mr, mr, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, r);
  endfunction
  function automatic out_t e_dec(logic [15:0] r);
    return o(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, r);
  endfunction
  function automatic out_t e_exec(logic [1:0] imm, logic bs, logic [3:0] alu, logic [15:0] r);
    return o(1'b0, 1'b0, 1'b0, 1'b1, imm, 1'b0, bs, alu, 1'b0, 1'b0, r);
  endfunction
  function automatic out_t e_mem(logic rw, logic [1:0] imm, logic bs, logic [3:0] alu, logic [15:0] r);
    return o(1'b0, 1'b0, 1'b1, rw, imm, 1'b0, bs, alu, 1'b0, 1'b0, r);
  endfunction
  function automatic out_t e_wb(logic wb, logic [1:0] imm, logic bs, logic [3:0] alu, logic [15:0] r);
    return o(1'b0, 1'b0, 1'b0, 1'b1, imm, 1'b1, bs, alu, wb, 1'b0, r);
  endfunction
  function automatic out_t e_trap(logic [15:0] r);
    return o(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, r);
  endfunction

  task automatic addv(input logic mr, input logic [31:0] in, input out_t exp);
    vec_t v;
    v.mr   = mr;
    v.inst = in;
    v.exp  = exp;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input out_t exp);
    out_t act;
    act = {PCWEn, IRWEn, MemReq, MemRW, ImmSel, RegWEn, Bsel, ALUSel, WBSel, illegal, retired};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (retired got %h want %h)", nm, act, exp,
               act.retired, exp.retired);
    end
    checks++;
    if (RegWEn && (PCWEn || IRWEn)) begin
      failures++;
      $display("FAIL %s_excl: RegWEn=%b PCWEn=%b IRWEn=%b want no overlap", nm,
               RegWEn, PCWEn, IRWEn);
    end
  endtask

  // Entered one time unit after a rising edge; checks on the falling edge.
  task automatic step(input string nm, input logic mr, input logic [31:0] in, input out_t exp);
    mem_ready = mr;
    inst      = in;
    @(negedge clk);
    chk(nm, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    inst      = 32'h0;

    // addi: 4 cycles, RegWEn pulse with WBSel=1, Bsel=1
    addv(1, I_ADDI, e_fetch(1, 0));
    addv(1, I_ADDI, e_dec(0));
    addv(1, I_ADDI, e_exec(2'b00, 1, 4'b0010, 0));
    addv(1, I_ADDI, e_wb(1, 2'b00, 1, 4'b0010, 0));
    // add: Bsel=0
    addv(1, I_ADD, e_fetch(1, 1));
    addv(1, I_ADD, e_dec(1));
    addv(1, I_ADD, e_exec(2'b00, 0, 4'b0010, 1));
    addv(1, I_ADD, e_wb(1, 2'b00, 0, 4'b0010, 1));
    // lui: U-type, pass-B
    addv(1, I_LUI, e_fetch(1, 2));
    addv(1, I_LUI, e_dec(2));
    addv(1, I_LUI, e_exec(2'b10, 1, 4'b0011, 2));
    addv(1, I_LUI, e_wb(1, 2'b10, 1, 4'b0011, 2));
    // lw without stall: 5 cycles
    addv(1, I_LW, e_fetch(1, 3));
    addv(1, I_LW, e_dec(3));
    addv(1, I_LW, e_exec(2'b00, 1, 4'b0010, 3));
    addv(1, I_LW, e_mem(1, 2'b00, 1, 4'b0010, 3));
    addv(1, I_LW, e_wb(0, 2'b00, 1, 4'b0010, 3));
    // lw with mem_ready low 3 cycles in MEM: 8 cycles total
    addv(1, I_LW, e_fetch(1, 4));
    addv(1, I_LW, e_dec(4));
    addv(1, I_LW, e_exec(2'b00, 1, 4'b0010, 4));
    addv(0, I_LW, e_mem(1, 2'b00, 1, 4'b0010, 4));
    addv(0, I_LW, e_mem(1, 2'b00, 1, 4'b0010, 4));
    addv(0, I_LW, e_mem(1, 2'b00, 1, 4'b0010, 4));
    addv(1, I_LW, e_mem(1, 2'b00, 1, 4'b0010, 4));
    addv(1, I_LW, e_wb(0, 2'b00, 1, 4'b0010, 4));
    // sw with fetch stall and one MEM stall: no RegWEn, write access
    addv(0, I_SW, e_fetch(0, 5));
    addv(0, I_SW, e_fetch(0, 5));
    addv(1, I_SW, e_fetch(1, 5));
    addv(1, I_SW, e_dec(5));
    addv(1, I_SW, e_exec(2'b01, 1, 4'b0010, 5));
    addv(0, I_SW, e_mem(0, 2'b01, 1, 4'b0010, 5));
    addv(1, I_SW, e_mem(0, 2'b01, 1, 4'b0010, 5));
    addv(0, I_SW, e_fetch(0, 6));

    // Reset is asynchronous: values visible before any clock edge
    #3;
    chk("reset_async", e_fetch(0, 0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vq[i]) begin
      step($sformatf("vec%0d", i), vq[i].mr, vq[i].inst, vq[i].exp);
    end

    // Counter wrap: force the count to 0xFFFF while an add is in flight
    step("wrap_fetch", 1, I_ADD, e_fetch(1, 6));
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    step("wrap_dec", 1, I_ADD, e_dec(16'hFFFF));
    step("wrap_exec", 1, I_ADD, e_exec(2'b00, 0, 4'b0010, 16'hFFFF));
    step("wrap_wb", 1, I_ADD, e_wb(1, 2'b00, 0, 4'b0010, 16'hFFFF));
    step("wrap_zero", 0, I_ADD, e_fetch(0, 16'h0000));

    // Reset during a stalled FETCH abandons the access
    step("pre_f", 1, I_ADDI, e_fetch(1, 0));
    step("pre_d", 1, I_ADDI, e_dec(0));
    step("pre_e", 1, I_ADDI, e_exec(2'b00, 1, 4'b0010, 0));
    step("pre_w", 1, I_ADDI, e_wb(1, 2'b00, 1, 4'b0010, 0));
    step("stall_f", 0, I_ADDI, e_fetch(0, 1));
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_midfetch", e_fetch(0, 0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post_rst0", 0, I_ADDI, e_fetch(0, 0));
    step("post_rst1", 0, I_ADDI, e_fetch(0, 0));
    step("post_rst_go", 1, I_ADDI, e_fetch(1, 0));
    step("post_rst_d", 1, I_ADDI, e_dec(0));
    step("post_rst_e", 1, I_ADDI, e_exec(2'b00, 1, 4'b0010, 0));
    step("post_rst_w", 1, I_ADDI, e_wb(1, 2'b00, 1, 4'b0010, 0));

    // Unsupported opcode: TRAP, no memory traffic, sticky until reset
    step("beq_f", 1, I_BEQ, e_fetch(1, 1));
    step("beq_d", 1, I_BEQ, e_dec(1));
    for (int k = 0; k < 20; k++) begin
      step($sformatf("trap%0d", k), logic'(k[0]), I_BEQ, e_trap(1));
    end
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("trap_clear", e_fetch(0, 0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // add encoding with non-zero funct7 is not in the legal set
    step("sub_f", 1, I_SUB, e_fetch(1, 0));
    step("sub_d", 1, I_SUB, e_dec(0));
    step("sub_t0", 1, I_SUB, e_trap(0));
    step("sub_t1", 0, I_SUB, e_trap(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-low reset; ports are clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 inst  input  32  instruction register contents; stable from DECODE until the next IRWEn.
REQ-005 mem_ready  input  1  memory completes current MemReq access this cycle.
REQ-006 PCWEn  output  1  PC register update enable, PC+4.
REQ-007 IRWEn  output  1  instruction register load enable.
REQ-008 MemReq  output  1  memory access request.
REQ-009 MemRW  output  1  1 = read, 0 = write.
REQ-010 ImmSel  output  2  00 I-type, 01 S-type, 10 U-type.
REQ-011 RegWEn  output  1  register file write enable.
REQ-012 Bsel  output  1  ALU operand B: 0 = rs2, 1 = immediate.
REQ-013 ALUSel  output  4  0010 add, 0011 pass-B.
REQ-014 WBSel  output  1  0 = memory data, 1 = ALU result.
REQ-015 illegal  output  1  sticky flag: unsupported instruction decoded.
REQ-016 retired  output  16  count of completed instructions.

Function
REQ-017 States SHALL be FETCH, DECODE, EXEC, MEM, WB and TRAP; outputs SHALL be combinational from state and inst only, with no X values (unused outputs = 0).
REQ-018 FETCH: MemReq=1, MemRW=1; hold while mem_ready=0; on mem_ready=1 assert IRWEn=1 and PCWEn=1 for that cycle -> DECODE.
REQ-019 DECODE: legal set = add (opcode 0110011, funct3 000, funct7 0000000), lw (0000011/010), sw (0100011/010), addi (0010011/000), lui (0110111); legal -> EXEC, otherwise -> TRAP.
REQ-020 EXEC: ALUSel/Bsel/ImmSel driven per instruction (add: Bsel=0, ALUSel=0010; lw/addi: ImmSel=00, Bsel=1, 0010; sw: ImmSel=01, Bsel=1, 0010; lui: ImmSel=10, Bsel=1, 0011); lw/sw -> MEM, else -> WB.
REQ-021 MEM: MemReq=1, MemRW=1 for lw and 0 for sw, ALU controls held as in EXEC; hold while mem_ready=0; on mem_ready lw -> WB, sw -> FETCH with retired increment.
REQ-022 WB: RegWEn=1 for exactly one cycle, WBSel=0 for lw else 1, ALU controls held; -> FETCH with retired increment.
REQ-023 Latency with mem_ready tied high: add/addi/lui 4 cycles, lw 5, sw 4.
REQ-024 TRAP: all enables 0, illegal=1, retired frozen; exit only by reset.
REQ-025 retired SHALL wrap from 0xFFFF to 0x0000.
REQ-026 RegWEn, PCWEn and IRWEn SHALL never be asserted in the same cycle, and MemReq=0 with MemRW=0 SHALL never occur outside MEM for sw.

Reset
REQ-027 While rst_n=0: state=FETCH, illegal=0, retired=0, independent of clk.
REQ-028 Reset asserted mid-access SHALL abandon the access; the first cycle after release SHALL present FETCH outputs.

Structure
REQ-029 Opcode, funct3, funct7, ImmSel, ALUSel and state encodings SHALL be defined as constants in a shared package riscv_pkg.
REQ-030 Instruction decode (legal flag plus per-instruction ImmSel/Bsel/ALUSel/WBSel) SHALL be a separate combinational sub-module inst_decode, and the sequencing, counter and flag SHALL stay in multicycle_ctrl.

Verification
REQ-031 addi x1,x0,5 with mem_ready=1 -> FETCH,DECODE,EXEC,WB in 4 cycles; RegWEn pulse 1 cycle with WBSel=1, Bsel=1; retired=1.
REQ-032 lw with mem_ready low 3 cycles in MEM -> MemReq=1, MemRW=1 held 4 cycles; then WB with WBSel=0; total 8 cycles.
REQ-033 sw -> MEM with MemRW=0, ImmSel=01; no RegWEn pulse at any point; back to FETCH; retired increments.
REQ-034 Opcode 1100011 -> TRAP after DECODE; illegal=1; no further MemReq over 20 cycles; rst_n pulse clears illegal to 0.
REQ-035 Preload 65535 retirements (or force the count), then one add -> retired=0x0000.
REQ-036 rst_n low during FETCH wait with mem_ready=0 -> immediate FETCH with retired=0, and IRWEn does not pulse until a fresh mem_ready.
